// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forwarding select encoding, stage tag layout
// and the slot-liveness helper used by the hazard logic.
package pipeline_pkg;

    // Operand mux select encoding
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    // Tag dest field is sized for the widest register number supported;
    // narrower register numbers are zero-extended into it.
    localparam int TAG_DEST_W = 8;

    localparam logic [TAG_DEST_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic                  wreg;
        logic [TAG_DEST_W-1:0] dest;
        logic                  is_load;
    } stage_tag_t;

    localparam int TAG_W = $bits(stage_tag_t);

    // A slot can only source a result when it really writes a non-zero register
    function automatic logic tag_live(input stage_tag_t t);
        return t.valid & t.wreg & (t.dest != REG_ZERO);
    endfunction

endpackage

// File: rtl/stage_tag_reg.sv
// One slot of the destination-tag pipeline (EX, MEM or WB).
module stage_tag_reg
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] tag_d,
    output logic [TAG_W-1:0] tag_q
);

    // Capture the upstream tag every cycle; reset empties the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller: tracks destination tags of EX/MEM/WB, derives operand
// forwarding selects and the load-use stall, and counts stall cycles.
module hazard_forward_unit
    import pipeline_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_tag_t ex_tag_d;
    stage_tag_t ex_tag_q;
    stage_tag_t mem_tag_q;
    stage_tag_t wb_tag_q;

    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [TAG_DEST_W-1:0] rs_ext;
    logic [TAG_DEST_W-1:0] rt_ext;
    logic [TAG_DEST_W-1:0] dest_ext;

    assign rs_ext   = TAG_DEST_W'(id_rs);
    assign rt_ext   = TAG_DEST_W'(id_rt);
    assign dest_ext = TAG_DEST_W'(id_dest);

    // Youngest live producer wins; register 0 and unused operands read the RF
    function automatic logic [1:0] fwd_select(
        input logic                  use_op,
        input logic [TAG_DEST_W-1:0] src,
        input stage_tag_t            ex_t,
        input stage_tag_t            mem_t,
        input stage_tag_t            wb_t
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_op && (src != REG_ZERO)) begin
            if (tag_live(ex_t) && (ex_t.dest == src)) begin
                sel = FWD_EX;
            end else if (tag_live(mem_t) && (mem_t.dest == src)) begin
                sel = FWD_MEM;
            end else if (tag_live(wb_t) && (wb_t.dest == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    stage_tag_reg u_ex_tag (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_d (ex_tag_d),
        .tag_q (ex_tag_q)
    );

    stage_tag_reg u_mem_tag (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_d (ex_tag_q),
        .tag_q (mem_tag_q)
    );

    stage_tag_reg u_wb_tag (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_d (mem_tag_q),
        .tag_q (wb_tag_q)
    );

    // Operand selects follow the current match even while stalled
    always_comb begin
        fwd_a_sel = fwd_select(id_use_rs, rs_ext, ex_tag_q, mem_tag_q, wb_tag_q);
        fwd_b_sel = fwd_select(id_use_rt, rt_ext, ex_tag_q, mem_tag_q, wb_tag_q);
    end

    // Load in EX feeding an operand in ID costs one bubble; a flush overrides it
    always_comb begin
        logic rs_hit;
        logic rt_hit;
        rs_hit = id_use_rs && (rs_ext == ex_tag_q.dest);
        rt_hit = id_use_rt && (rt_ext == ex_tag_q.dest);
        stall  = id_valid && !flush && tag_live(ex_tag_q) && ex_tag_q.is_load
                 && (rs_hit || rt_hit);
    end

    // Next EX tag: the ID instruction, or a bubble when it must not advance
    always_comb begin
        ex_tag_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_tag_d.valid   = 1'b1;
            ex_tag_d.wreg    = id_wreg;
            ex_tag_d.dest    = dest_ext;
            ex_tag_d.is_load = id_is_load;
        end
    end

    // Stall counter wraps naturally at its width
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
